count_display_driver: RTL and testbench

Two-digit seven-segment display driver downstream of the 5-bit up/down counter. Samples the counter value and direction, converts the value to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes two common-anode digits. Final stage between the counter and the board display pins.

---
 rtl/count_display_driver.sv | 188 ++++++++++++++++++
 tb/tb_count_display_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// Two-digit common-anode seven-segment driver: samples a counter value, converts it to BCD
// with a sequential double-dabble engine and scans the digits. Macro COUNT_DISP_LZB_EN blanks a zero tens digit.
module count_display_driver #(
  parameter int CNT_W       = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] count_in,
  input  logic             dir_in,
  input  logic             sample_en,
  output logic [6:0]       seg_n,
  output logic             dp_n,
  output logic [1:0]       an_n,
  output logic             conv_busy
);

  localparam int SH_W = CNT_W + 8;
  localparam int BC_W = $clog2(CNT_W + 1);
  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam logic [RC_W-1:0] REFRESH_MAX = RC_W'(REFRESH_DIV - 1);
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_val_q, hold_val_d;
  logic             hold_dir_q, hold_dir_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] last_conv_q, last_conv_d;
  logic [CNT_W-1:0] conv_val_q, conv_val_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [RC_W-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic             sel_q, sel_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             dp_n_q, dp_n_d;
  logic [1:0]       an_n_q, an_n_d;
  logic [SH_W-1:0]  adj;

  // Sample stage: a new value only triggers a conversion if it differs from what is displayed.
  always_comb begin
    hold_val_d = hold_val_q;
    hold_dir_d = hold_dir_q;
    pend_d     = pend_q;
    if (state_q == ST_IDLE && pend_q) begin
      pend_d = 1'b0;
    end
    if (sample_en) begin
      hold_val_d = count_in;
      hold_dir_d = dir_in;
      if (count_in != last_conv_q) begin
        pend_d = 1'b1;
      end
    end
  end

  // Add-3 correction on each BCD nibble ahead of the shift.
  assign adj[CNT_W-1:0] = shreg_q[CNT_W-1:0];
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
      logic [3:0] nib;
      assign nib = shreg_q[CNT_W + 4*gi +: 4];
      assign adj[CNT_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    conv_val_d  = conv_val_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    last_conv_d = last_conv_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          shreg_d    = {8'b0, hold_val_q};
          conv_val_d = hold_val_q;
          bit_cnt_d  = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = adj << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Digits and last_conv commit together so a half-finished result is never shown.
        ones_d      = shreg_q[CNT_W +: 4];
        tens_d      = shreg_q[CNT_W + 4 +: 4];
        last_conv_d = conv_val_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign conv_busy = (state_q != ST_IDLE);

  // Scan stage runs freely; outputs are registered from the current digit select.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    sel_d         = sel_q;
    if (refresh_cnt_q == REFRESH_MAX) begin
      refresh_cnt_d = '0;
      sel_d         = ~sel_q;
    end

    seg_n_d = seg_decode(sel_q ? tens_q : ones_q);
`ifdef COUNT_DISP_LZB_EN
    if (sel_q && tens_q == 4'd0) begin
      seg_n_d = 7'h7F;
    end
`endif
    an_n_d = sel_q ? 2'b01 : 2'b10;
    dp_n_d = sel_q ? 1'b1 : ~hold_dir_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hold_val_q    <= '0;
      hold_dir_q    <= 1'b0;
      pend_q        <= 1'b0;
      last_conv_q   <= '0;
      conv_val_q    <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      ones_q        <= '0;
      tens_q        <= '0;
      refresh_cnt_q <= '0;
      sel_q         <= 1'b0;
      seg_n_q       <= 7'h7F;
      dp_n_q        <= 1'b1;
      an_n_q        <= 2'b11;
    end else begin
      state_q       <= state_d;
      hold_val_q    <= hold_val_d;
      hold_dir_q    <= hold_dir_d;
      pend_q        <= pend_d;
      last_conv_q   <= last_conv_d;
      conv_val_q    <= conv_val_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      ones_q        <= ones_d;
      tens_q        <= tens_d;
      refresh_cnt_q <= refresh_cnt_d;
      sel_q         <= sel_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: stimulus queues expected digits, a monitor
// checks the scanned display every cycle and pops a new entry at the end of each conversion.
module tb_count_display_driver;

  localparam int CNT_W = 5;
  localparam int RDIV  = 2;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG7 = 7'b1111000;
`ifdef COUNT_DISP_LZB_EN
  localparam logic [6:0] TENS0 = 7'h7F;
`else
  localparam logic [6:0] TENS0 = SEG0;
`endif

  typedef struct packed {
    logic [6:0] ones;
    logic [6:0] tens;
    logic [4:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] count_in;
  logic             dir_in;
  logic             sample_en;
  logic [6:0]       seg_n;
  logic             dp_n;
  logic [1:0]       an_n;
  logic             conv_busy;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  count_display_driver #(.CNT_W(CNT_W), .REFRESH_DIV(RDIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .count_in  (count_in),
    .dir_in    (dir_in),
    .sample_en (sample_en),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .conv_busy (conv_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input logic [4:0] v, input logic d, input logic conv,
                           input logic [6:0] o, input logic [6:0] t);
    exp_t e;
    count_in  = v;
    dir_in    = d;
    sample_en = 1'b1;
    if (conv) begin
      e.ones = o;
      e.tens = t;
      e.val  = v;
      exp_q.push_back(e);
    end
    $display("sample value %0d dir %0d conversion_expected %0d", v, d, conv);
    tick();
    sample_en = 1'b0;
  endtask

  // Monitor: display must always show the last committed digits; a busy fall commits the next entry.
  initial begin
    exp_t       cur;
    logic       busy_prev;
    logic       rst_seen;
    logic [1:0] an_prev;
    int         busy_run;
    int         an_run;
    cur.ones = SEG0; cur.tens = TENS0; cur.val = '0;
    busy_prev = 1'b0; rst_seen = 1'b0; an_prev = 2'b11; busy_run = 0; an_run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rst_seen = 1'b1;
        continue;
      end
      if (rst_seen) begin
        check("rst_seg", seg_n, 7'h7F);
        check("rst_an", an_n, 2'b11);
        check("rst_dp", dp_n, 1'b1);
        check("rst_busy", conv_busy, 1'b0);
        if (exp_q.size() > 0) $display("reset discards %0d queued conversion(s)", exp_q.size());
        exp_q.delete();
        cur.ones = SEG0; cur.tens = TENS0; cur.val = '0;
        busy_prev = 1'b0; rst_seen = 1'b0; an_prev = 2'b11; busy_run = 0; an_run = 0;
        continue;
      end
      if (an_n == 2'b10) check("ones_seg", seg_n, cur.ones);
      else if (an_n == 2'b01) check("tens_seg", seg_n, cur.tens);
      else check("an_scan", an_n, 2'b10);
      if (an_n != an_prev) begin
        if (an_prev != 2'b11) check("scan_period", an_run, RDIV);
        an_run  = 1;
        an_prev = an_n;
      end else begin
        an_run++;
      end
      if (conv_busy) begin
        busy_run++;
      end else if (busy_prev) begin
        check("busy_len", busy_run, CNT_W + 1);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_conv: actual conversion finished, required none at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          $display("conversion done, display now %0d", cur.val);
        end
      end
      busy_prev = conv_busy;
    end
  end

  initial begin
    reset_n   = 1'b0;
    sample_en = 1'b1;
    count_in  = 5'd9;
    dir_in    = 1'b0;

    // 1: reset held with a sample request present
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_seg", seg_n, 7'h7F);
      check("reset_an", an_n, 2'b11);
      check("reset_dp", dp_n, 1'b1);
      check("reset_busy", conv_busy, 1'b0);
    end
    reset_n   = 1'b1;
    sample_en = 1'b0;
    repeat (6) tick();

    // 2: basic conversion, busy starts one cycle after the sample
    do_sample(5'd13, 1'b0, 1'b1, SEG3, SEG1);
    check("busy_before", conv_busy, 1'b0);
    tick();
    check("busy_start", conv_busy, 1'b1);
    repeat (14) tick();

    // 3: single-digit value, tens zero
    do_sample(5'd7, 1'b0, 1'b1, SEG7, TENS0);
    repeat (14) tick();

    // 4: new sample while converting; both results appear in order
    do_sample(5'd13, 1'b0, 1'b1, SEG3, SEG1);
    tick();
    do_sample(5'd31, 1'b0, 1'b1, SEG1, SEG3);
    repeat (22) tick();

    // 5: reset three cycles into a conversion
    do_sample(5'd25, 1'b0, 1'b1, SEG5, SEG2);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_busy", conv_busy, 1'b0);
    check("midrst_seg", seg_n, 7'h7F);
    check("midrst_an", an_n, 2'b11);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("postrst_busy", conv_busy, 1'b0);
    end

    // 6: count-down direction lights the ones decimal point; duplicate sample is ignored
    do_sample(5'd31, 1'b1, 1'b1, SEG1, SEG3);
    repeat (12) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("dp_n", dp_n, (an_n == 2'b10) ? 1'b0 : 1'b1);
    end
    do_sample(5'd31, 1'b1, 1'b0, SEG1, SEG3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dup_busy", conv_busy, 1'b0);
    end

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
